// File: rtl/lsu_bus_if.sv
// Load/store unit between the core control FSM and a valid/ready data-memory bus.
// One transaction in flight at a time; every output is driven from a register.
module lsu_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  lsu_reqValid,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_signed,
    output logic                  lsu_respValid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_reqValid,
    input  logic                  mem_reqReady,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_respValid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_respErr
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_t;

    state_t                state_q, state_d;
    size_t                 size_q, size_d, size_in;
    logic [1:0]            lane_q, lane_d;
    logic                  signed_q, signed_d;
    logic                  wen_q, wen_d;
    logic                  outstanding_q, outstanding_d;

    logic                  resp_valid_d;
    logic [DATA_W-1:0]     rdata_d;
    logic                  err_d;
    logic                  req_valid_d;
    logic [ADDR_W-1:0]     maddr_d;
    logic                  mwen_d;
    logic [DATA_W-1:0]     mwdata_d;
    logic [DATA_W/8-1:0]   mwstrb_d;

    logic                  bad_req;
    logic [DATA_W-1:0]     st_wdata;
    logic [DATA_W/8-1:0]   st_wstrb;
    logic [DATA_W-1:0]     lane;
    logic [DATA_W-1:0]     load_ext;

    assign size_in = size_t'(lsu_size);
    assign bad_req = (size_in == SZ_BAD)
                   || ((size_in == SZ_HALF) && lsu_addr[0])
                   || ((size_in == SZ_WORD) && (lsu_addr[1:0] != 2'b00));

    // Store lanes are replicated so the memory only needs to honour the strobes.
    always_comb begin
        st_wdata = lsu_wdata;
        st_wstrb = '1;
        case (size_in)
            SZ_BYTE: begin
                st_wdata = {4{lsu_wdata[7:0]}};
                st_wstrb = 4'b0001 << lsu_addr[1:0];
            end
            SZ_HALF: begin
                st_wdata = {2{lsu_wdata[15:0]}};
                st_wstrb = 4'b0011 << {lsu_addr[1], 1'b0};
            end
            default: begin
                st_wdata = lsu_wdata;
                st_wstrb = '1;
            end
        endcase
        if (!lsu_wen) begin
            st_wstrb = '0;
        end
    end

    assign lane = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_BYTE: load_ext = signed_q ? {{(DATA_W-8){lane[7]}}, lane[7:0]}
                                         : {{(DATA_W-8){1'b0}}, lane[7:0]};
            SZ_HALF: load_ext = signed_q ? {{(DATA_W-16){lane[15]}}, lane[15:0]}
                                         : {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        lane_d        = lane_q;
        signed_d      = signed_q;
        wen_d         = wen_q;
        outstanding_d = outstanding_q;
        resp_valid_d  = 1'b0;
        rdata_d       = lsu_rdata;
        err_d         = lsu_err;
        req_valid_d   = mem_reqValid;
        maddr_d       = mem_addr;
        mwen_d        = mem_wen;
        mwdata_d      = mem_wdata;
        mwstrb_d      = mem_wstrb;

        case (state_q)
            ST_IDLE: begin
                if (lsu_reqValid) begin
                    size_d   = size_in;
                    lane_d   = lsu_addr[1:0];
                    signed_d = lsu_signed;
                    wen_d    = lsu_wen;
                    if (bad_req) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        maddr_d     = {lsu_addr[ADDR_W-1:2], 2'b00};
                        mwen_d      = lsu_wen;
                        mwdata_d    = st_wdata;
                        mwstrb_d    = st_wstrb;
                    end
                end
            end
            ST_REQ: begin
                // A response coinciding with acceptance is not legal and is not looked at here.
                if (mem_reqReady) begin
                    state_d       = ST_WAIT;
                    req_valid_d   = 1'b0;
                    outstanding_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_respValid && outstanding_q) begin
                    state_d       = ST_RESP;
                    outstanding_d = 1'b0;
                    resp_valid_d  = 1'b1;
                    err_d         = mem_respErr;
                    rdata_d       = (wen_q || mem_respErr) ? '0 : load_ext;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            size_q        <= SZ_BYTE;
            lane_q        <= '0;
            signed_q      <= 1'b0;
            wen_q         <= 1'b0;
            outstanding_q <= 1'b0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= '0;
            lsu_err       <= 1'b0;
            mem_reqValid  <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            signed_q      <= signed_d;
            wen_q         <= wen_d;
            outstanding_q <= outstanding_d;
            lsu_respValid <= resp_valid_d;
            lsu_rdata     <= rdata_d;
            lsu_err       <= err_d;
            mem_reqValid  <= req_valid_d;
            mem_addr      <= maddr_d;
            mem_wen       <= mwen_d;
            mem_wdata     <= mwdata_d;
            mem_wstrb     <= mwstrb_d;
        end
    end

`ifndef SYNTHESIS
    // The control FSM must wait for lsu_respValid before issuing another request.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(lsu_reqValid && (state_q != ST_IDLE)))
                else $warning("lsu_reqValid outside IDLE ignored");
        end
    end
`endif

endmodule
